// File: rtl/uart_fifo.sv
// Byte FIFO between the UART receiver and its consumers.
// Define UART_FIFO_FWFT_EN for first-word-fall-through reads.
module uart_fifo #(
    parameter int p_width = 8,
    parameter int p_depth = 16
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic [p_width-1:0]         i_wr_data,
    input  logic                       i_wr_en,
    output logic                       o_full,
    input  logic                       i_rd_en,
    output logic [p_width-1:0]         o_rd_data,
    output logic                       o_rd_valid,
    output logic                       o_empty,
    output logic [$clog2(p_depth):0]   o_count,
    output logic                       o_overflow
);

    localparam int aw = $clog2(p_depth);
    localparam logic [aw:0] c_depth = p_depth[aw:0];
    localparam logic [aw-1:0] c_ptr_one = {{(aw-1){1'b0}}, 1'b1};
    localparam logic [aw:0] c_cnt_one = {{aw{1'b0}}, 1'b1};

    logic [p_width-1:0] mem [p_depth];
    logic [aw-1:0] wp;
    logic [aw-1:0] rp;
    logic [aw:0] cnt;
    logic wr_ok;
    logic rd_ok;

    assign o_full  = (cnt == c_depth);
    assign o_empty = (cnt == '0);
    assign o_count = cnt;

    // Flags come from registered cnt, so a same-cycle read never frees a slot for a write.
    assign wr_ok = i_wr_en & ~o_full;
    assign rd_ok = i_rd_en & ~o_empty;

    always_ff @(posedge i_clk) begin
        if (wr_ok) begin
            mem[wp] <= i_wr_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wp         <= '0;
            rp         <= '0;
            cnt        <= '0;
            o_overflow <= 1'b0;
        end else begin
            if (wr_ok) begin
                wp <= wp + c_ptr_one;
            end
            if (rd_ok) begin
                rp <= rp + c_ptr_one;
            end
            case ({wr_ok, rd_ok})
                2'b10:   cnt <= cnt + c_cnt_one;
                2'b01:   cnt <= cnt - c_cnt_one;
                default: cnt <= cnt;
            endcase
            if (i_wr_en && o_full) begin
                o_overflow <= 1'b1;
            end
        end
    end

`ifdef UART_FIFO_FWFT_EN
    // Head word is shown directly; zero while empty so reset state is clean.
    assign o_rd_data  = o_empty ? '0 : mem[rp];
    assign o_rd_valid = ~o_empty;
`else
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_rd_data  <= '0;
            o_rd_valid <= 1'b0;
        end else begin
            o_rd_valid <= rd_ok;
            if (rd_ok) begin
                o_rd_data <= mem[rp];
            end
        end
    end
`endif

endmodule

// File: tb/tb_uart_fifo.sv
// Scoreboard bench for uart_fifo: directed writes/pops, monitor checks popped words.
module tb_uart_fifo;

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b1;
    logic [7:0] i_wr_data = 8'h00;
    logic       i_wr_en = 1'b0;
    logic       i_rd_en = 1'b0;
    logic       o_full;
    logic [7:0] o_rd_data;
    logic       o_rd_valid;
    logic       o_empty;
    logic [4:0] o_count;
    logic       o_overflow;

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] expq [$];
    logic take;

    uart_fifo #(.p_width(8), .p_depth(16)) dut (
        .i_clk(i_clk),
        .i_rst(i_rst),
        .i_wr_data(i_wr_data),
        .i_wr_en(i_wr_en),
        .o_full(o_full),
        .i_rd_en(i_rd_en),
        .o_rd_data(o_rd_data),
        .o_rd_valid(o_rd_valid),
        .o_empty(o_empty),
        .o_count(o_count),
        .o_overflow(o_overflow)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle; a pop with expectation pushes the word it must return.
    task automatic step(input logic we, input logic [7:0] wd,
                        input logic re, input logic pe, input logic [7:0] ed);
        if (pe) expq.push_back(ed);
        i_wr_en   = we;
        i_wr_data = wd;
        i_rd_en   = re;
        @(posedge i_clk);
        #1;
        i_wr_en = 1'b0;
        i_rd_en = 1'b0;
    endtask

    always @(negedge i_clk) begin
        if (!i_rst) begin
`ifdef UART_FIFO_FWFT_EN
            take = o_rd_valid && i_rd_en;
`else
            take = o_rd_valid;
`endif
            if (take) begin
                n_cmp++;
                if (expq.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_pop: got %0h expected none", o_rd_data);
                end else begin
                    logic [7:0] e;
                    e = expq.pop_front();
                    if (o_rd_data != e) begin
                        n_bad++;
                        $display("FAIL pop_data: got %0h expected %0h", o_rd_data, e);
                    end
                end
            end
        end
    end

    initial begin
        repeat (2) @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        chk("rst_count", o_count, 0);
        chk("rst_empty", o_empty, 1);
        chk("rst_full", o_full, 0);
        chk("rst_valid", o_rd_valid, 0);
        chk("rst_ovf", o_overflow, 0);
        chk("rst_data", o_rd_data, 0);

        step(1, 8'h41, 0, 0, 0);
        chk("w1_count", o_count, 1);
        step(1, 8'h42, 0, 0, 0);
        step(1, 8'h43, 0, 0, 0);
        chk("w3_count", o_count, 3);
        step(0, 0, 1, 1, 8'h41);
        step(0, 0, 1, 1, 8'h42);
        chk("p2_count", o_count, 1);
        step(0, 0, 1, 1, 8'h43);
        chk("p3_count", o_count, 0);
        chk("p3_empty", o_empty, 1);
        step(0, 0, 0, 0, 0);

        for (int i = 0; i < 16; i++) step(1, 8'h20 + 8'(i), 0, 0, 0);
        chk("fill_full", o_full, 1);
        chk("fill_count", o_count, 16);
        chk("fill_ovf", o_overflow, 0);
        step(1, 8'hFF, 0, 0, 0);
        chk("ovf_set", o_overflow, 1);
        chk("ovf_count", o_count, 16);
        step(0, 0, 1, 1, 8'h20);
        chk("unfull", o_full, 0);
        for (int i = 1; i < 16; i++) step(0, 0, 1, 1, 8'h20 + 8'(i));
        chk("drain_empty", o_empty, 1);
        step(0, 0, 0, 0, 0);

        for (int i = 0; i < 16; i++) step(1, 8'h10 + 8'(i), 0, 0, 0);
        step(1, 8'hEE, 1, 1, 8'h10);
        chk("fullrw_count", o_count, 15);
        chk("fullrw_ovf", o_overflow, 1);
        for (int i = 1; i < 16; i++) step(0, 0, 1, 1, 8'h10 + 8'(i));
        chk("fullrw_empty", o_empty, 1);
        step(0, 0, 0, 0, 0);

        step(1, 8'h5A, 1, 0, 0);
`ifndef UART_FIFO_FWFT_EN
        chk("emptyrw_valid", o_rd_valid, 0);
`endif
        chk("emptyrw_count", o_count, 1);
        step(0, 0, 1, 1, 8'h5A);
        chk("emptyrw_after", o_count, 0);
        step(0, 0, 0, 0, 0);

        for (int i = 0; i < 5; i++) step(1, 8'h80 + 8'(i), 0, 0, 0);
        for (int i = 0; i < 40; i++) begin
            step(1, 8'h85 + 8'(i), 1, 1, 8'h80 + 8'(i));
            chk("wrap_count", o_count, 5);
        end
        for (int i = 40; i < 45; i++) step(0, 0, 1, 1, 8'h80 + 8'(i));
        chk("wrap_empty", o_empty, 1);
        step(0, 0, 0, 0, 0);

        for (int i = 0; i < 7; i++) step(1, 8'h60 + 8'(i), 0, 0, 0);
        chk("pre_rst_count", o_count, 7);
        chk("pre_rst_ovf", o_overflow, 1);
        i_rst = 1'b1;
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        chk("mid_rst_count", o_count, 0);
        chk("mid_rst_empty", o_empty, 1);
        chk("mid_rst_full", o_full, 0);
        chk("mid_rst_ovf", o_overflow, 0);
        chk("mid_rst_valid", o_rd_valid, 0);
        step(0, 0, 1, 0, 0);
        chk("ign_pop_valid", o_rd_valid, 0);
        chk("ign_pop_count", o_count, 0);
        repeat (3) step(0, 0, 0, 0, 0);
        chk("scoreboard_left", expq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_fifo.md
# uart_fifo

Synchronous single-clock FIFO that buffers bytes delivered by the UART receiver's write port and hands them to downstream consumers (command parser, UART transmitter loopback) through a read port. Write side matches the receiver: data plus one-cycle write strobe, with a full flag returned. Read side is a pop strobe with registered data and a valid flag. First-word-fall-through is a compile-time option.

## Interface
- p_width, 8: data word width in bits.
- p_depth, 16: number of storage entries; power of two, ≥ 2.

- i_clk  in  1  clock; all logic on rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_wr_data  in  p_width  write word.
- i_wr_en  in  1  write strobe; one word per cycle.
- o_full  out  1  high when count == p_depth.
- i_rd_en  in  1  pop strobe.
- o_rd_data  out  p_width  read word.
- o_rd_valid  out  1  o_rd_data holds a popped/head word.
- o_empty  out  1  high when count == 0.
- o_count  out  $clog2(p_depth)+1  current occupancy, 0..p_depth.
- o_overflow  out  1  sticky: a write was attempted while full.

## Operation
- Storage: p_depth × p_width array; write pointer wp, read pointer rp, each $clog2(p_depth) bits, wrapping naturally from p_depth-1 to 0; occupancy register cnt drives o_count.
- Write accepted iff i_wr_en & ~o_full: mem[wp] <= i_wr_data, wp <= wp+1.
- Read accepted iff i_rd_en & ~o_empty: rp <= rp+1.
- cnt: +1 on accepted write only, −1 on accepted read only, unchanged when both or neither.
- Simultaneous i_wr_en & i_rd_en:
  - Full: read accepted, write dropped, o_overflow set, count → p_depth−1.
  - Empty: write accepted, read ignored, count → 1.
  - Otherwise: both accepted, count unchanged.
- Flags are decoded from the registered cnt, so they reflect the state at the start of the cycle. A write in the same cycle as a read never frees a slot for itself.
- Rejected writes never modify memory or pointers. Rejected reads do not move rp or assert o_rd_valid.
- o_overflow: set on i_wr_en & o_full; cleared only by reset.
- Reset (mid-operation included): wp = rp = cnt = 0, o_empty=1, o_full=0, o_rd_valid=0, o_rd_data=0, o_overflow=0. Memory contents are not cleared and are don't-care.

## Timing
- Write-to-visible: a word written in cycle N is reflected in o_count/o_empty in cycle N+1. It can be popped starting in cycle N+1.
- Standard mode read latency is 1. Accepted pop in cycle N gives o_rd_data = mem[rp] and o_rd_valid=1 in cycle N+1. o_rd_valid is 0 in any cycle following a non-accepted read. o_rd_data holds its last value.
- Back-to-back pops sustain one word per cycle. Back-to-back writes sustain one word per cycle until full.
- Full condition asserts the cycle after the p_depth-th accepted write, and deasserts the cycle after the first accepted read.

## Configuration
- UART_FIFO_FWFT_EN defined (first-word-fall-through):
  - o_rd_data = mem[rp] combinationally; o_rd_valid = ~o_empty.
  - i_rd_en acknowledges and drops the presented word. The next head appears the following cycle.
  - Ports are unchanged; all flag, count and overflow rules are unchanged.
- Not defined: registered read, latency 1, as in Timing.

## Test plan
- Reset, then write 0x41, 0x42, 0x43 on consecutive cycles, then pop 3 on consecutive cycles -> o_rd_data 0x41, 0x42, 0x43 with o_rd_valid high one cycle after each pop (FWFT: 0x41 presented before the first pop); o_count 3→0; o_empty returns to 1.
- Fill with 16 writes (p_depth=16) -> o_full=1 and o_count=16 the cycle after; 17th write 0xFF dropped and o_overflow=1; 16 pops return the original values in order, with no 0xFF.
- Full with i_wr_en & i_rd_en asserted together -> read returns the oldest word, write dropped, o_count=15, o_overflow=1.
- Empty with i_wr_en & i_rd_en asserted together -> o_rd_valid stays 0, o_count=1; a pop next cycle returns the written word.
- Wrap: 40 write/pop interleaved cycles with the FIFO kept at occupancy 5 -> data order preserved across pointer wrap; o_count constant at 5.
- Assert i_rst with o_count=7 and o_overflow=1 -> next cycle o_count=0, o_empty=1, o_full=0, o_overflow=0, o_rd_valid=0; a pop is then ignored.
